// File: rtl/fpu_pkg.sv
// fpu_pkg
//   Float format constants, status bit indices and the encoder state type
//   shared between the operand encoder and the FPU.
//   Format: sign[31], exp[30:25] (bias 31), mant[24:0] with a hidden leading 1.
package fpu_pkg;

  localparam int FP_EXP_W   = 6;
  localparam int FP_MAN_W   = 25;
  localparam int FP_BIAS    = 31;
  localparam int FP_EXP_MAX = 62;

  // status_out = {ZERO, INEXACT, OVERFLOW, UNDERFLOW}
  localparam int ST_ZERO      = 3;
  localparam int ST_INEXACT   = 2;
  localparam int ST_OVERFLOW  = 1;
  localparam int ST_UNDERFLOW = 0;

  typedef enum logic [2:0] {
    ENC_IDLE  = 3'd0,
    ENC_ABS   = 3'd1,
    ENC_NORM  = 3'd2,
    ENC_ROUND = 3'd3,
    ENC_DONE  = 3'd4
  } enc_state_t;

endpackage

// File: rtl/fp_pack_round.sv
// fp_pack_round
//   Combinational round and pack of a normalised magnitude into the FPU float
//   format. The leading 1 is implied; only the bits below it are supplied.
//   Optional feature macro: ENCODER_RNE_EN (round-to-nearest-even); when it is
//   undefined the result is truncated toward zero.
// Ports
//   sign     in   1         sign of the original value
//   frac     in   DATA_W-1  bits below the hidden 1
//   exp_cnt  in   8 signed  biased exponent before rounding
//   data     out  32        packed float
//   status   out  4         {ZERO, INEXACT, OVERFLOW, UNDERFLOW}
module fp_pack_round
  import fpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                sign,
  input  logic [DATA_W-2:0]   frac,
  input  logic signed [7:0]   exp_cnt,
  output logic [31:0]         data,
  output logic [3:0]          status
);

  // Zero padding below frac so the mantissa, guard and sticky fields exist
  // for any DATA_W, including widths narrower than the mantissa.
  localparam int EXT_W = DATA_W + FP_MAN_W;
  localparam logic signed [8:0] EXP_MAX_S = 9'(FP_EXP_MAX);

  logic [EXT_W-1:0]      ext;
  logic [FP_MAN_W-1:0]   mant;
  logic                  guard;
  logic                  sticky;
  logic                  inc;
  logic [FP_MAN_W:0]     mant_sum;
  logic                  carry;
  logic [FP_MAN_W-1:0]   mant_r;
  logic signed [8:0]     exp_r;

  assign ext    = {frac, {(FP_MAN_W + 1){1'b0}}};
  assign mant   = ext[EXT_W-1 -: FP_MAN_W];
  assign guard  = ext[EXT_W-FP_MAN_W-1];
  assign sticky = |ext[EXT_W-FP_MAN_W-2:0];

`ifdef ENCODER_RNE_EN
  assign inc = guard & (sticky | mant[0]);
`else
  assign inc = 1'b0;
`endif

  assign mant_sum = {1'b0, mant} + {{FP_MAN_W{1'b0}}, inc};
  assign carry    = mant_sum[FP_MAN_W];
  // A carry out of the mantissa means 1.111..1 rounded up to 10.000..0.
  assign mant_r   = carry ? '0 : mant_sum[FP_MAN_W-1:0];
  assign exp_r    = {exp_cnt[7], exp_cnt} + {8'd0, carry};

  always_comb begin
    data               = '0;
    status             = '0;
    status[ST_INEXACT] = guard | sticky;
    if (exp_r < 9'sd1) begin
      status[ST_ZERO]      = 1'b1;
      status[ST_UNDERFLOW] = 1'b1;
    end else if (exp_r > EXP_MAX_S) begin
      // Exponent 63 is reserved; saturate to the largest finite value.
      data                = {sign, FP_EXP_W'(FP_EXP_MAX), {FP_MAN_W{1'b1}}};
      status[ST_OVERFLOW] = 1'b1;
    end else begin
      data = {sign, exp_r[FP_EXP_W-1:0], mant_r};
    end
  end

endmodule

// File: rtl/fpu_operand_encoder.sv
// fpu_operand_encoder
//   Converts a signed fixed-point value into the FPU float format, normalising
//   one bit per clock. valid/ready handshake on input and output.
//   Optional feature macro: ENCODER_RNE_EN (round-to-nearest-even, applied in
//   fp_pack_round); default build truncates toward zero.
// Ports
//   clock_100kHz  in   1       rising-edge clock
//   reset         in   1       async active-low reset
//   in_valid      in   1       in_data is valid
//   in_ready      out  1       encoder can accept a value
//   in_data       in   DATA_W  two's-complement fixed-point value
//   out_valid     out  1       data_out/status_out valid
//   out_ready     in   1       consumer takes the result
//   data_out      out  32      encoded float
//   status_out    out  4       {ZERO, INEXACT, OVERFLOW, UNDERFLOW}
//
// state     | meaning
// ENC_IDLE  | waiting for in_valid, in_ready=1
// ENC_ABS   | take magnitude, load exponent, detect zero
// ENC_NORM  | shift left one bit per clock until the leading 1 reaches the top
// ENC_ROUND | round, range-check and register the packed result
// ENC_DONE  | out_valid=1, hold result until out_ready
module fpu_operand_encoder
  import fpu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 0
) (
  input  logic              clock_100kHz,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       data_out,
  output logic [3:0]        status_out
);

  localparam logic signed [7:0] EXP_INIT = 8'(FP_BIAS + DATA_W - 1 - FRAC_BITS);

  enc_state_t        state;
  logic              sign_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] abs_val;
  // Bits below the magnitude MSB. In NORM the MSB is known to be 0 and in
  // ROUND it is the hidden 1, so it never needs to be stored.
  logic [DATA_W-2:0] mag_lo;
  logic signed [7:0] exp_cnt;
  logic [31:0]       pack_data;
  logic [3:0]        pack_status;

  // Unsigned result, so -2^(DATA_W-1) maps to 2^(DATA_W-1) exactly.
  assign abs_val = sign_q ? (~data_q + DATA_W'(1)) : data_q;

  fp_pack_round #(.DATA_W(DATA_W)) u_pack (
    .sign    (sign_q),
    .frac    (mag_lo),
    .exp_cnt (exp_cnt),
    .data    (pack_data),
    .status  (pack_status)
  );

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      state      <= ENC_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      data_out   <= '0;
      status_out <= '0;
      sign_q     <= 1'b0;
      data_q     <= '0;
      mag_lo     <= '0;
      exp_cnt    <= '0;
    end else begin
      case (state)
        ENC_IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            sign_q   <= in_data[DATA_W-1];
            in_ready <= 1'b0;
            state    <= ENC_ABS;
          end
        end
        ENC_ABS: begin
          mag_lo  <= abs_val[DATA_W-2:0];
          exp_cnt <= EXP_INIT;
          if (abs_val == '0) begin
            data_out   <= '0;
            status_out <= 4'b1 << ST_ZERO;
            out_valid  <= 1'b1;
            state      <= ENC_DONE;
          end else if (abs_val[DATA_W-1]) begin
            state <= ENC_ROUND;
          end else begin
            state <= ENC_NORM;
          end
        end
        ENC_NORM: begin
          // Leave as soon as this shift brings the leading 1 to the top.
          mag_lo  <= mag_lo << 1;
          exp_cnt <= exp_cnt - 8'sd1;
          if (mag_lo[DATA_W-2]) begin
            state <= ENC_ROUND;
          end
        end
        ENC_ROUND: begin
          data_out   <= pack_data;
          status_out <= pack_status;
          out_valid  <= 1'b1;
          state      <= ENC_DONE;
        end
        ENC_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ENC_IDLE;
          end
        end
        default: begin
          state     <= ENC_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
